pipelined_addsub: RTL

//   Parametrised, pipelined two's-complement add/subtract unit for the 2D-DCT butterfly datapath.

---
 rtl/dct_arith_pkg.sv | 17 +
 rtl/addsub_segment.sv | 23 ++
 rtl/pipelined_addsub.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dct_arith_pkg.sv
// Shared arithmetic constants and saturation limits for the 2D-DCT butterfly datapath.
package dct_arith_pkg;

  localparam int unsigned DCT_WIDTH = 24;
  localparam int unsigned DCT_SEG_W = 8;

  // Largest positive two's-complement value of width w, zero-extended to 64 bits.
  function automatic logic [63:0] max_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width w, zero-extended to 64 bits.
  function automatic logic [63:0] max_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_segment.sv
// One SEG_W-bit slice of the segmented carry chain; purely combinational.
module addsub_segment #(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             cin,
  output logic [SEG_W-1:0] s_seg,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SEG_W:0] full;

  always_comb begin
    full     = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, cin};
    s_seg    = full[SEG_W-1:0];
    cout     = full[SEG_W];
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
    c_msb_in = s_seg[SEG_W-1] ^ a_seg[SEG_W-1] ^ b_seg[SEG_W-1];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract with one register stage per carry segment,
// valid/ready handshake, signed overflow detection and optional saturation.
module pipelined_addsub
  import dct_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DCT_WIDTH,
  parameter int unsigned SEG_W = DCT_SEG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSEG = WIDTH / SEG_W;
  localparam int unsigned LAST = NSEG - 1;
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(max_neg(WIDTH));

  logic adv;

  // Stage k inputs. The working word holds computed sum bits below segment k and
  // still-unprocessed A bits from segment k upward.
  logic             st_v   [NSEG];
  logic [WIDTH-1:0] st_w   [NSEG];
  logic [WIDTH-1:0] st_b   [NSEG];
  logic             st_c   [NSEG];
  logic             st_sat [NSEG];

  logic [WIDTH-1:0] nxt_w  [NSEG];
  logic             seg_co [NSEG];
  logic             seg_cm [NSEG];

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, ovf_q, ovf_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign st_v[0]   = in_valid;
  assign st_w[0]   = a;
  assign st_b[0]   = b ^ {WIDTH{sub}};
  assign st_c[0]   = sub;
  assign st_sat[0] = sat;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SEG_W-1:0] s_seg;
    logic [WIDTH-1:0] w_d;

    addsub_segment #(.SEG_W(SEG_W)) u_seg (
      .a_seg    (st_w[k][k*SEG_W +: SEG_W]),
      .b_seg    (st_b[k][k*SEG_W +: SEG_W]),
      .cin      (st_c[k]),
      .s_seg    (s_seg),
      .cout     (seg_co[k]),
      .c_msb_in (seg_cm[k])
    );

    always_comb begin
      w_d = st_w[k];
      w_d[k*SEG_W +: SEG_W] = s_seg;
    end
    assign nxt_w[k] = w_d;

    if (k < LAST) begin : g_reg
      logic             v_q, c_q, sat_q;
      logic [WIDTH-1:0] w_q, b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (adv) begin
          v_q   <= st_v[k];
          w_q   <= w_d;
          b_q   <= st_b[k];
          c_q   <= seg_co[k];
          sat_q <= st_sat[k];
        end
      end

      assign st_v[k+1]   = v_q;
      assign st_w[k+1]   = w_q;
      assign st_b[k+1]   = b_q;
      assign st_c[k+1]   = c_q;
      assign st_sat[k+1] = sat_q;
    end
  end

  // Top segment still carries A's MSB in the working word, so the clamp direction
  // needs no separate copy of the original operand.
  always_comb begin
    ovf_d = seg_co[LAST] ^ seg_cm[LAST];
    sum_d = nxt_w[LAST];
    if (st_sat[LAST] && ovf_d) begin
      sum_d = st_w[LAST][WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= st_v[LAST];
      if (st_v[LAST]) begin
        sum_q  <= sum_d;
        cout_q <= seg_co[LAST];
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
